// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared definitions for the front-end pipeline: datapath widths, default
//   reset PC and the fetch-queue entry layout.
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    // One fetch-queue slot. 'filled' marks that the instruction word has come
    // back from instruction memory; until then only pc/pred are meaningful.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               pred;
        logic               filled;
    } fq_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the instruction-memory request/response channels and the
//   IF->ID handshake of the fetch unit.
//   master : fetch unit side (drives requests and ID outputs)
//   slave  : environment side (instruction memory + decode stage)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    import pipeline_pkg::*;

    // instruction memory
    logic               o_imem_req_valid;
    logic               i_imem_req_ready;
    logic [XLEN-1:0]    o_imem_addr;
    logic               i_imem_rsp_valid;
    logic [INSTR_W-1:0] i_imem_rsp_data;

    // decode stage
    logic               o_ID_valid;
    logic               i_ID_ready;
    logic [INSTR_W-1:0] o_ID_instr;
    logic [XLEN-1:0]    o_ID_pc;
    logic               o_ID_pred_taken;

    modport master (
        output o_imem_req_valid, o_imem_addr,
        input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
        output o_ID_valid, o_ID_instr, o_ID_pc, o_ID_pred_taken,
        input  i_ID_ready
    );

    modport slave (
        input  o_imem_req_valid, o_imem_addr,
        output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
        input  o_ID_valid, o_ID_instr, o_ID_pc, o_ID_pred_taken,
        output i_ID_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Circular buffer of fetch entries with three pointers:
//     tail : next slot to allocate at request issue
//     fill : oldest allocated slot still waiting for its instruction word
//     head : oldest slot, presented to decode
//   Pointers carry one extra wrap bit so full/empty need no separate count.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-low reset
//   flush               drop every entry and rewind all pointers
//   alloc, alloc_pc, alloc_pred   allocate tail entry
//   fill, fill_instr    complete the entry at the fill pointer
//   pop                 release the head entry
//   head_entry          current head slot contents
//   alloc_count         allocated entries (filled or not)
//   unfilled_count      allocated entries still awaiting data
// -----------------------------------------------------------------------------
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter  int FQ_DEPTH = 4,
    localparam int AW       = $clog2(FQ_DEPTH),
    localparam int PW       = AW + 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               flush,
    input  logic               alloc,
    input  logic [XLEN-1:0]    alloc_pc,
    input  logic               alloc_pred,
    input  logic               fill,
    input  logic [INSTR_W-1:0] fill_instr,
    input  logic               pop,
    output fq_entry_t          head_entry,
    output logic [PW-1:0]      alloc_count,
    output logic [PW-1:0]      unfilled_count
);

    fq_entry_t     entries_q [FQ_DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [PW-1:0] fill_q;

    assign alloc_count    = tail_q - head_q;
    assign unfilled_count = tail_q - fill_q;
    assign head_entry     = entries_q[head_q[AW-1:0]];

    // alloc/fill/pop never hit the same slot in one cycle: alloc is only
    // allowed when not full, fill targets an allocated-but-unfilled slot and
    // pop targets a filled one.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) entries_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
            fill_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < FQ_DEPTH; i++) entries_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
            fill_q <= '0;
        end else begin
            if (alloc) begin
                entries_q[tail_q[AW-1:0]] <= '{pc: alloc_pc, instr: '0,
                                              pred: alloc_pred, filled: 1'b0};
                tail_q <= tail_q + PW'(1);
            end
            if (fill) begin
                entries_q[fill_q[AW-1:0]].instr  <= fill_instr;
                entries_q[fill_q[AW-1:0]].filled <= 1'b1;
                fill_q <= fill_q + PW'(1);
            end
            if (pop) begin
                entries_q[head_q[AW-1:0]] <= '0;
                head_q <= head_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   IF-stage PC generator and instruction fetch buffer.
// Ports:
//   i_clk, i_reset       clock, asynchronous active-low reset
//   o_IF_pc, o_IF_pc_4   current fetch PC and PC+4, to the branch predictor
//   i_IF_pc_target       next PC from the predictor (predicted or corrected)
//   i_IF_hit             predictor says taken for o_IF_pc
//   i_branch_flush       misprediction redirect
//   bus                  imem request/response and IF->ID handshake
// -----------------------------------------------------------------------------
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              FQ_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic [XLEN-1:0] o_IF_pc,
    output logic [XLEN-1:0] o_IF_pc_4,
    input  logic [XLEN-1:0] i_IF_pc_target,
    input  logic            i_IF_hit,
    input  logic            i_branch_flush,
    fetch_unit_if.master    bus
);

    localparam int PW = $clog2(FQ_DEPTH) + 1;
    localparam int SW = $clog2(2 * FQ_DEPTH) + 1;

    logic [XLEN-1:0] pc_q;
    logic [SW-1:0]   stale_q;

    fq_entry_t       head;
    logic [PW-1:0]   alloc_count;
    logic [PW-1:0]   unfilled_count;
    logic            req_ok;
    logic            issue;
    logic            stale_zero;
    logic            fill;
    logic            id_valid;
    logic            pop;

    assign o_IF_pc         = pc_q;
    assign o_IF_pc_4       = pc_q + 32'd4;
    assign bus.o_imem_addr = pc_q;

    // Occupancy is taken before any same-cycle pop, so a full queue always
    // costs one bubble before the next request.
    assign req_ok               = ~i_branch_flush & (alloc_count < PW'(FQ_DEPTH));
    assign issue                = req_ok & bus.i_imem_req_ready;
    assign bus.o_imem_req_valid = req_ok & i_reset;

    // Responses to requests issued before a flush are swallowed by stale_q.
    assign stale_zero = (stale_q == '0);
    assign fill       = bus.i_imem_rsp_valid & stale_zero & ~i_branch_flush;

    assign id_valid            = head.filled & ~i_branch_flush;
    assign pop                 = id_valid & bus.i_ID_ready;
    assign bus.o_ID_valid      = id_valid;
    assign bus.o_ID_instr      = head.instr;
    assign bus.o_ID_pc         = head.pc;
    assign bus.o_ID_pred_taken = head.pred;

    fetch_queue #(.FQ_DEPTH(FQ_DEPTH)) u_queue (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .flush          (i_branch_flush),
        .alloc          (issue),
        .alloc_pc       (pc_q),
        .alloc_pred     (i_IF_hit),
        .fill           (fill),
        .fill_instr     (bus.i_imem_rsp_data),
        .pop            (pop),
        .head_entry     (head),
        .alloc_count    (alloc_count),
        .unfilled_count (unfilled_count)
    );

    // On flush every still-unfilled request becomes stale; a response landing
    // in the flush cycle itself retires one of the outstanding ones, whether it
    // belonged to an older stale request or a just-killed live one.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q    <= RESET_PC;
            stale_q <= '0;
        end else if (i_branch_flush) begin
            pc_q    <= i_IF_pc_target;
            stale_q <= stale_q + SW'(unfilled_count) - SW'(bus.i_imem_rsp_valid);
        end else begin
            if (issue) pc_q <= i_IF_pc_target;
            if (bus.i_imem_rsp_valid && !stale_zero) stale_q <= stale_q - SW'(1);
        end
    end

    // A live response always has an allocated, unfilled slot waiting for it.
    a_rsp_has_slot: assert property (@(posedge i_clk) disable iff (!i_reset)
        (bus.i_imem_rsp_valid && stale_zero) |-> (unfilled_count != '0));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import pipeline_pkg::*;

    typedef struct packed {
        logic [31:0] taken_pc;
        logic [31:0] taken_tgt;
        logic [3:0]  lat;
    } cfg_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc, if_pc_4, pc_target;
    logic        hit, flush;
    logic [31:0] taken_pc, taken_tgt, flush_tgt;
    logic        imem_ready, id_ready;
    int          lat;

    req_t        inflight[$];
    logic [31:0] req_log[$];
    exp_t        id_log[$];
    int          n_edge, n_issue;
    int          n_vec = 0;
    int          n_err = 0;

    cfg_t        cfgs[4];
    exp_t        exps[4][6];

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0), .FQ_DEPTH(4)) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .o_IF_pc        (if_pc),
        .o_IF_pc_4      (if_pc_4),
        .i_IF_pc_target (pc_target),
        .i_IF_hit       (hit),
        .i_branch_flush (flush),
        .bus            (bus)
    );

    // Branch predictor stand-in: one taken branch, otherwise fall-through.
    assign hit       = (if_pc == taken_pc);
    assign pc_target = flush ? flush_tgt : (hit ? taken_tgt : if_pc_4);

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: called at a negedge, drives inputs, samples just before
    // the coming posedge, returns at the following negedge.
    task automatic step();
        if (inflight.size() > 0 && inflight[0].due <= 32'(n_edge)) begin
            bus.i_imem_rsp_valid = 1'b1;
            bus.i_imem_rsp_data  = instr_of(inflight[0].addr);
        end else begin
            bus.i_imem_rsp_valid = 1'b0;
            bus.i_imem_rsp_data  = '0;
        end
        bus.i_imem_req_ready = imem_ready;
        bus.i_ID_ready       = id_ready;
        #1;
        if (bus.i_imem_rsp_valid) void'(inflight.pop_front());
        if (bus.o_imem_req_valid && bus.i_imem_req_ready) begin
            inflight.push_back('{addr: bus.o_imem_addr, due: 32'(n_edge + lat)});
            req_log.push_back(bus.o_imem_addr);
            n_issue++;
        end
        if (bus.o_ID_valid && bus.i_ID_ready)
            id_log.push_back('{pc: bus.o_ID_pc, instr: bus.o_ID_instr, pred: bus.o_ID_pred_taken});
        n_edge++;
        @(negedge clk);
    endtask

    task automatic clear_bench();
        flush                = 1'b0;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = '0;
        inflight.delete();
        req_log.delete();
        id_log.delete();
        n_issue = 0;
        n_edge  = 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_bench();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_id(input string tag, input int idx, input logic [31:0] pc,
                          input logic [31:0] instr, input logic pred);
        if (idx < id_log.size()) begin
            chk($sformatf("%s_pc%0d", tag, idx), id_log[idx].pc, pc);
            chk($sformatf("%s_instr%0d", tag, idx), id_log[idx].instr, instr);
            chk($sformatf("%s_pred%0d", tag, idx), 32'(id_log[idx].pred), 32'(pred));
        end else begin
            chk($sformatf("%s_missing%0d", tag, idx), 32'(id_log.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        cfgs[0] = '{taken_pc: 32'h2,  taken_tgt: 32'h0,         lat: 4'd1};
        cfgs[1] = '{taken_pc: 32'h10, taken_tgt: 32'h100,       lat: 4'd1};
        cfgs[2] = '{taken_pc: 32'h2,  taken_tgt: 32'h0,         lat: 4'd3};
        cfgs[3] = '{taken_pc: 32'h4,  taken_tgt: 32'hFFFF_FFF8, lat: 4'd2};
        exps[0] = '{'{32'h00, 32'hC0DE_0000, 1'b0}, '{32'h04, 32'hC0DE_0004, 1'b0},
                    '{32'h08, 32'hC0DE_0008, 1'b0}, '{32'h0C, 32'hC0DE_000C, 1'b0},
                    '{32'h10, 32'hC0DE_0010, 1'b0}, '{32'h14, 32'hC0DE_0014, 1'b0}};
        exps[1] = '{'{32'h00, 32'hC0DE_0000, 1'b0}, '{32'h04, 32'hC0DE_0004, 1'b0},
                    '{32'h08, 32'hC0DE_0008, 1'b0}, '{32'h0C, 32'hC0DE_000C, 1'b0},
                    '{32'h10, 32'hC0DE_0010, 1'b1}, '{32'h100, 32'hC0DE_0100, 1'b0}};
        exps[2] = exps[0];
        exps[3] = '{'{32'h0, 32'hC0DE_0000, 1'b0}, '{32'h4, 32'hC0DE_0004, 1'b1},
                    '{32'hFFFF_FFF8, 32'h3F21_FFF8, 1'b0}, '{32'hFFFF_FFFC, 32'h3F21_FFFC, 1'b0},
                    '{32'h0, 32'hC0DE_0000, 1'b0}, '{32'h4, 32'hC0DE_0004, 1'b1}};

        rst_n = 1'b1; imem_ready = 1'b1; id_ready = 1'b1; lat = 1;
        taken_pc = 32'h2; taken_tgt = '0; flush_tgt = '0;
        bus.i_imem_req_ready = 1'b1; bus.i_ID_ready = 1'b1;
        clear_bench();

        // Reset state while reset is held.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 32'(bus.o_imem_req_valid), 32'h0);
        chk("rst_id_valid",  32'(bus.o_ID_valid), 32'h0);
        chk("rst_id_instr",  bus.o_ID_instr, 32'h0);
        chk("rst_id_pc",     bus.o_ID_pc, 32'h0);
        chk("rst_id_pred",   32'(bus.o_ID_pred_taken), 32'h0);
        chk("rst_if_pc",     if_pc, 32'h0);
        chk("rst_if_pc_4",   if_pc_4, 32'h4);
        @(negedge clk);

        // Table: free-running fetch under different predictor/latency setups.
        for (int v = 0; v < 4; v++) begin
            taken_pc  = cfgs[v].taken_pc;
            taken_tgt = cfgs[v].taken_tgt;
            lat       = int'(cfgs[v].lat);
            do_reset();
            repeat (30) step();
            if (v == 0) begin
                chk("seq_req0", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h0);
                chk("seq_req1", (req_log.size() > 1) ? req_log[1] : 32'hDEAD_BEEF, 32'h4);
                chk("seq_req2", (req_log.size() > 2) ? req_log[2] : 32'hDEAD_BEEF, 32'h8);
            end
            for (int j = 0; j < 6; j++)
                chk_id($sformatf("vec%0d", v), j, exps[v][j].pc, exps[v][j].instr, exps[v][j].pred);
        end
        taken_pc = 32'h2;

        // Flush with three unfilled requests, no response on the flush edge
        // (latency 4 so the first response lands one cycle after the flush).
        lat = 4;
        do_reset();
        repeat (3) step();
        chk("flA_issued", 32'(n_issue), 32'd3);
        flush_tgt = 32'h200;
        flush = 1'b1;
        #1;
        chk("flA_id_valid_flush", 32'(bus.o_ID_valid), 32'h0);
        chk("flA_req_valid_flush", 32'(bus.o_imem_req_valid), 32'h0);
        step();
        flush = 1'b0;
        chk("flA_id_valid_after", 32'(bus.o_ID_valid), 32'h0);
        chk("flA_pc_after", if_pc, 32'h200);
        repeat (25) step();
        chk_id("flA", 0, 32'h200, 32'hC0DE_0200, 1'b0);
        chk_id("flA", 1, 32'h204, 32'hC0DE_0204, 1'b0);

        // Flush with two unfilled requests and a response on the flush edge.
        lat = 3;
        do_reset();
        step();
        step();
        imem_ready = 1'b0;
        step();
        imem_ready = 1'b1;
        chk("flB_issued", 32'(n_issue), 32'd2);
        flush_tgt = 32'h300;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (25) step();
        chk_id("flB", 0, 32'h300, 32'hC0DE_0300, 1'b0);
        chk_id("flB", 1, 32'h304, 32'hC0DE_0304, 1'b0);

        // Decode back-pressure fills the queue, then drains in order.
        lat = 1;
        do_reset();
        id_ready = 1'b0;
        repeat (10) step();
        chk("bp_issued", 32'(n_issue), 32'd4);
        chk("bp_req_valid", 32'(bus.o_imem_req_valid), 32'h0);
        chk("bp_pc_held", if_pc, 32'h10);
        chk("bp_head_valid", 32'(bus.o_ID_valid), 32'h1);
        chk("bp_head_pc", bus.o_ID_pc, 32'h0);
        id_ready = 1'b1;
        repeat (20) step();
        for (int j = 0; j < 5; j++)
            chk_id("bp", j, 32'(4 * j), 32'hC0DE_0000 | 32'(4 * j), 1'b0);
        chk("bp_resume_req", (req_log.size() > 4) ? req_log[4] : 32'hDEAD_BEEF, 32'h10);

        // Asynchronous reset in the middle of traffic.
        lat = 2;
        do_reset();
        id_ready = 1'b0;
        repeat (3) step();
        chk("ar_pre_id_valid", 32'(bus.o_ID_valid), 32'h1);
        chk("ar_pre_id_instr", bus.o_ID_instr, 32'hC0DE_0000);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req_valid", 32'(bus.o_imem_req_valid), 32'h0);
        chk("ar_id_valid",  32'(bus.o_ID_valid), 32'h0);
        chk("ar_id_pc",     bus.o_ID_pc, 32'h0);
        chk("ar_id_instr",  bus.o_ID_instr, 32'h0);
        chk("ar_if_pc",     if_pc, 32'h0);
        clear_bench();
        @(negedge clk);
        rst_n = 1'b1;
        id_ready = 1'b1;
        repeat (15) step();
        chk("ar_req0", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h0);
        chk("ar_req1", (req_log.size() > 1) ? req_log[1] : 32'hDEAD_BEEF, 32'h4);
        chk_id("ar", 0, 32'h0, 32'hC0DE_0000, 1'b0);
        chk_id("ar", 1, 32'h4, 32'hC0DE_0004, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
